// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes.
// The signs of the quotient and remainder are applied in a final FIX cycle.
// Optional feature macro: MULDIV_ABORT_EN adds an Abort input that cancels
// an operation in flight.
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              HiWrite,
  input  logic              LoWrite,
  input  logic [DATA_W-1:0] MoveData,
`ifdef MULDIV_ABORT_EN
  input  logic              Abort,
`endif
  output logic              Busy,
  output logic              Done,
  output logic              DivZero,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } stateType;

  stateType state, nextState;
  logic accept, finish;

  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] accHi, accLo, opB;
  logic              isDiv, resNeg, remNeg, zeroDiv;

  logic              opSigned, negA, negB;
  logic [DATA_W-1:0] absA, absB;
  logic [DATA_W:0]   mulSum, divShift, divDiff;
  logic [2*DATA_W-1:0] mulNext, divNext, stepNext, product, prodFix;
  logic [DATA_W-1:0] quoFix, remFix, finHi, finLo;

  assign Busy = (state != IDLE);

  // State register; reset discards any operation in flight
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic plus the accept/finish strobes that steer the datapath
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept    = 1'b1;
          nextState = CALC;
        end
      end
      CALC: begin
        if (counter == LAST_ITER) nextState = FIX;
      end
      FIX: begin
        finish    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
`ifdef MULDIV_ABORT_EN
    if (Abort && (state != IDLE)) begin
      nextState = IDLE;
      finish    = 1'b0;
    end
`endif
  end

  // Operand magnitudes for the signed ops; unsigned ops pass raw values
  always_comb begin
    opSigned = ~Op[0];
    negA     = opSigned & OperandA[DATA_W-1];
    negB     = opSigned & OperandB[DATA_W-1];
    absA     = negA ? (~OperandA + 1'b1) : OperandA;
    absB     = negB ? (~OperandB + 1'b1) : OperandB;
  end

  // One radix-2 iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    mulSum = {1'b0, accHi} + {1'b0, opB};
    if (accLo[0]) mulNext = {mulSum, accLo[DATA_W-1:1]};
    else          mulNext = {1'b0, accHi, accLo[DATA_W-1:1]};
    divShift = {accHi, accLo[DATA_W-1]};
    divDiff  = divShift - {1'b0, opB};
    if (divShift >= {1'b0, opB}) divNext = {divDiff[DATA_W-1:0], accLo[DATA_W-2:0], 1'b1};
    else                         divNext = {divShift[DATA_W-1:0], accLo[DATA_W-2:0], 1'b0};
    stepNext = isDiv ? divNext : mulNext;
  end

  // Sign correction; a zero divisor forces an all-ones quotient and the
  // sign-corrected remainder reproduces the original dividend
  always_comb begin
    product = {accHi, accLo};
    prodFix = resNeg ? (~product + 1'b1) : product;
    quoFix  = resNeg ? (~accLo + 1'b1) : accLo;
    remFix  = remNeg ? (~accHi + 1'b1) : accHi;
    if (isDiv) begin
      finHi = remFix;
      finLo = zeroDiv ? {DATA_W{1'b1}} : quoFix;
    end else begin
      finHi = prodFix[2*DATA_W-1:DATA_W];
      finLo = prodFix[DATA_W-1:0];
    end
  end

  // Iteration datapath: load on accept, step once per CALC cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      counter <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      isDiv   <= 1'b0;
      resNeg  <= 1'b0;
      remNeg  <= 1'b0;
      zeroDiv <= 1'b0;
    end else if (accept) begin
      counter <= '0;
      accHi   <= '0;
      accLo   <= Op[1] ? absA : absB;
      opB     <= Op[1] ? absB : absA;
      isDiv   <= Op[1];
      resNeg  <= negA ^ negB;
      remNeg  <= negA;
      zeroDiv <= Op[1] & (OperandB == '0);
    end else if (state == CALC) begin
      counter        <= counter + CNT_W'(1);
      {accHi, accLo} <= stepNext;
    end
  end

  // Architectural HI/LO, MTHI/MTLO moves in IDLE, Done pulse and DivZero flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Hi      <= '0;
      Lo      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done <= finish;
      if (state == IDLE) begin
        if (HiWrite) Hi <= MoveData;
        if (LoWrite) Lo <= MoveData;
      end
      if (accept) DivZero <= 1'b0;
      if (finish) begin
        Hi      <= finHi;
        Lo      <= finLo;
        DivZero <= zeroDiv;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the register file's two read-data values and implements MULT, MULTU, DIV and DIVU.
- Results go into architectural HI/LO registers, read out by MFHI/MFLO.
- Uses a start/busy/done handshake so the pipeline stalls while an operation is in flight.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; accepted only when Busy=0.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- OperandA  input  DATA_W  rs value (register file ReadData1); dividend or multiplicand.
- OperandB  input  DATA_W  rt value (register file ReadData2); divisor or multiplier.
- HiWrite  input  1  MTHI strobe.
- LoWrite  input  1  MTLO strobe.
- MoveData  input  DATA_W  data for MTHI/MTLO.
- Busy  output  1  high from the cycle after acceptance until Done.
- Done  output  1  one-cycle pulse when Hi/Lo are updated.
- DivZero  output  1  sticky flag: last divide had OperandB=0; cleared on next accepted Start.
- Hi  output  DATA_W  HI register.
- Lo  output  DATA_W  LO register.

Behaviour:
- Reset low (asynchronous, at any time, including mid-operation):
  - State=IDLE; Busy=0, Done=0, DivZero=0, Hi=0, Lo=0; counter=0.
  - Any operation in flight is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start=1 at an edge E0 → latch |A|, |B| (signed ops) or raw values (unsigned ops); latch the result sign, remainder sign and Op; clear DivZero.
  - Move to CALC with counter=0; Busy=1 from E0.
- CALC: one radix-2 iteration per edge; counter increments; after DATA_W iterations move to FIX.
  - Multiply: shift-add on a 2*DATA_W accumulator.
  - Divide: restoring division, one quotient bit per iteration.
- FIX (one edge): apply sign correction, write Hi/Lo, assert Done for one cycle, set Busy=0, return to IDLE.
- Latency: Done=1 and Hi/Lo valid in the cycle after edge E0+DATA_W+1, i.e. DATA_W+2 edges including the accepting edge (34 for the default).
  - Next Start is accepted at the edge where Done=1 is observed.
- Multiply result: Hi = upper DATA_W bits, Lo = lower DATA_W bits of the full product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide result: Lo = quotient, truncated toward zero; Hi = remainder, with the sign of the dividend.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives Lo=0x80000000, Hi=0; DivZero=0.
- Divide by zero (OperandB=0): same latency; Lo=all ones, Hi=OperandA as given; DivZero=1.
- Start while Busy=1: ignored, no side effect.
- HiWrite/LoWrite:
  - In IDLE: written on the next edge; both may be written in the same cycle.
  - While Busy=1: ignored.
  - HiWrite together with an accepted Start: the move applies, and the completing result later overwrites it.
- Operands are latched at acceptance; OperandA/B may change freely afterwards.

Optional Feature:
- MULDIV_ABORT_EN defined:
  - Adds input Abort (1 bit).
  - Abort=1 in CALC or FIX → IDLE at that edge; Busy=0; no Done; Hi/Lo/DivZero unchanged; iteration state discarded.
  - Abort in IDLE has no effect.
  - Abort and Start in the same IDLE cycle: Start wins.
- Not defined: no Abort port; an accepted operation always runs to completion unless Reset is asserted.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 34 edges Done=1 for one cycle, Hi=0xFFFFFFFE, Lo=0x00000001, Busy=0.
- MULT A=0xFFFFFFFD (-3), B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100, B=0 → Lo=0xFFFFFFFF, Hi=100, DivZero=1; then DIVU 100/7 → DivZero clears at Start; Lo=14, Hi=2.
- Start a MULT, pulse Start with different operands at cycle 5 and HiWrite with MoveData=0x1234 at cycle 10 → both ignored; only the first result lands; Done pulses once.
- Reset low at cycle 15 of a DIV → Busy/Done/Hi/Lo=0 immediately, before the next edge; no Done after release; a new MTLO of 0xA5A5A5A5 in IDLE → Lo=0xA5A5A5A5 next edge.
- With MULDIV_ABORT_EN: Abort at CALC cycle 8 of a MULT after a prior Hi=3, Lo=4 → IDLE next edge; Hi=3, Lo=4; no Done pulse.
